// File: rtl/hazard_pkg.sv
// Shared types, default occupancy constants and the forwarding-select helper
// for the pipeline hazard controller.
package hazard_pkg;

  localparam int MULT_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF  = 32;
  localparam int CNT_W           = 6;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_t;

  // M wins over W: it holds the younger write to the same register.
  function automatic fwd_sel_t fwd_sel(input logic [4:0] src,
                                       input logic       rw_m,
                                       input logic [4:0] wr_m,
                                       input logic       rw_w,
                                       input logic [4:0] wr_w);
    fwd_sel = FWD_RF;
    if (src != 5'd0 && rw_w && src == wr_w) fwd_sel = FWD_WB;
    if (src != 5'd0 && rw_m && src == wr_m) fwd_sel = FWD_MEM;
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// Mult/div occupancy tracker: IDLE/RUN FSM with a 6-bit down-counter.
// md_busy is purely registered state, so md_start never reaches it combinationally.
module md_sequencer
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start,
  input  logic md_div,
  output logic md_busy
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // A start seen while RUN is dropped; the D-stage stall keeps that from happening.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (md_start) begin
        state_nx = RUN;
        cnt_nx   = md_div ? DIV_LOAD : MULT_LOAD;
      end
      RUN: if (cnt == CNT_W'(1)) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt - CNT_W'(1);
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign md_busy = (state == RUN);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Five-stage hazard unit: operand forwarding, load-use / branch / mult-div
// stall detection, plus the mult/div occupancy sequencer.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic       branch_d,
  input  logic       md_use_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_e,
  input  logic       reg_write_e,
  input  logic       mem_to_reg_e,
  input  logic [4:0] write_reg_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_m,
  input  logic       mem_to_reg_m,
  input  logic       reg_write_w,
  input  logic       md_start_e,
  input  logic       md_div_e,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_e,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       fwd_a_d,
  output logic       fwd_b_d,
  output logic       md_busy
);

  logic lw_stall, br_stall, md_stall, stall;
  logic e_hits_d, m_hits_d;

  assign fwd_a_e = fwd_sel(rs_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);
  assign fwd_b_e = fwd_sel(rt_e, reg_write_m, write_reg_m, reg_write_w, write_reg_w);

  assign fwd_a_d = (rs_d != 5'd0) && reg_write_m && (rs_d == write_reg_m);
  assign fwd_b_d = (rt_d != 5'd0) && reg_write_m && (rt_d == write_reg_m);

  assign lw_stall = mem_to_reg_e && (rt_e != 5'd0) && ((rs_d == rt_e) || (rt_d == rt_e));

  // Branch compares in D, so an ALU result still in E or a load still in M
  // cannot be forwarded in time.
  assign e_hits_d = reg_write_e && (write_reg_e != 5'd0) &&
                    ((write_reg_e == rs_d) || (write_reg_e == rt_d));
  assign m_hits_d = mem_to_reg_m && (write_reg_m != 5'd0) &&
                    ((write_reg_m == rs_d) || (write_reg_m == rt_d));
  assign br_stall = branch_d && (e_hits_d || m_hits_d);

  assign md_stall = md_use_d && md_busy;

  assign stall   = lw_stall | br_stall | md_stall;
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;

  md_sequencer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_start (md_start_e),
    .md_div   (md_div_e),
    .md_busy  (md_busy)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scenarios then randomized traffic, checked against a reference
// model that tracks mult/div occupancy as a count of remaining busy cycles.
module tb_pipeline_hazard_controller;

  localparam int MULT_C = 4;
  localparam int DIV_C  = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic       branch_d, md_use_d, reg_write_e, mem_to_reg_e;
  logic       reg_write_m, mem_to_reg_m, reg_write_w, md_start_e, md_div_e;
  logic       stall_f, stall_d, flush_e, fwd_a_d, fwd_b_d, md_busy;
  logic [1:0] fwd_a_e, fwd_b_e;

  int checks = 0;
  int errors = 0;
  int busy_left = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
    .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
    .md_use_d(md_use_d), .rs_e(rs_e), .rt_e(rt_e), .write_reg_e(write_reg_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
    .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
    .reg_write_w(reg_write_w), .md_start_e(md_start_e), .md_div_e(md_div_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .md_busy(md_busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd_e(input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (reg_write_m && src == write_reg_m) return 2'b10;
    if (reg_write_w && src == write_reg_w) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic m_stall();
    logic lw, br, md;
    lw = mem_to_reg_e && rt_e != 0 && (rs_d == rt_e || rt_d == rt_e);
    br = branch_d && ((reg_write_e && write_reg_e != 0 && (write_reg_e == rs_d || write_reg_e == rt_d)) ||
                      (mem_to_reg_m && write_reg_m != 0 && (write_reg_m == rs_d || write_reg_m == rt_d)));
    md = md_use_d && (busy_left > 0);
    return lw | br | md;
  endfunction

  // Compare every output against the model a moment after inputs settle.
  task automatic check_all(input string tag);
    logic s;
    #1;
    if (!rst_n) busy_left = 0;
    s = m_stall();
    chk({tag, ".stall_f"}, 8'(stall_f), 8'(s));
    chk({tag, ".stall_d"}, 8'(stall_d), 8'(s));
    chk({tag, ".flush_e"}, 8'(flush_e), 8'(s));
    chk({tag, ".fwd_a_e"}, 8'(fwd_a_e), 8'(m_fwd_e(rs_e)));
    chk({tag, ".fwd_b_e"}, 8'(fwd_b_e), 8'(m_fwd_e(rt_e)));
    chk({tag, ".fwd_a_d"}, 8'(fwd_a_d), 8'(rs_d != 0 && reg_write_m && rs_d == write_reg_m));
    chk({tag, ".fwd_b_d"}, 8'(fwd_b_d), 8'(rt_d != 0 && reg_write_m && rt_d == write_reg_m));
    chk({tag, ".md_busy"}, 8'(md_busy), 8'(busy_left > 0));
  endtask

  // Advance one clock, updating the occupancy model with the inputs held over the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) busy_left = 0;
    else if (busy_left > 0) busy_left--;
    else if (md_start_e) busy_left = (md_div_e ? DIV_C : MULT_C) - 1;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    {rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w} = '0;
    {branch_d, md_use_d, reg_write_e, mem_to_reg_e} = '0;
    {reg_write_m, mem_to_reg_m, reg_write_w, md_start_e, md_div_e} = '0;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    check_all("reset");
    chk("reset_busy_const", 8'(md_busy), 8'd0);
    tick();
    rst_n = 1'b1;
    check_all("idle");

    // Load-use: lw $2 in E, consumer in D.
    mem_to_reg_e = 1; reg_write_e = 1; rt_e = 2; write_reg_e = 2; rs_d = 2; rt_d = 7;
    check_all("lw_use");
    chk("lw_use_const", 8'(stall_f), 8'd1);
    tick();
    clear_inputs();
    mem_to_reg_m = 1; reg_write_m = 1; write_reg_m = 2; rs_d = 2; rt_d = 7;
    check_all("lw_bubble");
    chk("lw_bubble_const", 8'(stall_d), 8'd0);
    tick();
    clear_inputs();
    reg_write_w = 1; write_reg_w = 2; rs_e = 2; rt_e = 7;
    check_all("lw_wb_fwd");
    chk("lw_wb_fwd_const", 8'(fwd_a_e), 8'b01);
    tick();

    // M beats W on the same register; $0 never forwards.
    clear_inputs();
    reg_write_m = 1; write_reg_m = 5; reg_write_w = 1; write_reg_w = 5; rs_e = 5;
    check_all("m_prio");
    chk("m_prio_const", 8'(fwd_a_e), 8'b10);
    write_reg_m = 0; rs_e = 0;
    check_all("zero_reg");
    chk("zero_reg_const", 8'(fwd_a_e), 8'b00);
    tick();

    // Branch on a register E is producing, then forward from M.
    clear_inputs();
    branch_d = 1; rs_d = 3; reg_write_e = 1; write_reg_e = 3;
    check_all("br_e");
    chk("br_e_const", 8'(flush_e), 8'd1);
    tick();
    reg_write_e = 0; write_reg_e = 0; reg_write_m = 1; write_reg_m = 3;
    check_all("br_m");
    chk("br_m_stall_const", 8'(stall_f), 8'd0);
    chk("br_m_fwd_const", 8'(fwd_a_d), 8'd1);
    tick();

    // Multiply occupancy then divide occupancy.
    clear_inputs();
    md_start_e = 1;
    check_all("mul_issue");
    tick();
    md_start_e = 0; md_use_d = 1;
    for (int i = 0; i < MULT_C - 1; i++) begin
      check_all("mul_busy");
      chk("mul_busy_const", 8'(stall_f), 8'd1);
      tick();
    end
    check_all("mul_done");
    chk("mul_done_const", 8'(md_busy), 8'd0);
    md_use_d = 0; md_start_e = 1; md_div_e = 1;
    tick();
    md_start_e = 0; md_use_d = 1;
    for (int i = 0; i < DIV_C - 1; i++) begin
      check_all("div_busy");
      tick();
    end
    check_all("div_done");
    chk("div_done_const", 8'(stall_f), 8'd0);

    // Reset in the middle of a divide.
    md_use_d = 0; md_start_e = 1; md_div_e = 1;
    tick();
    md_start_e = 0;
    for (int i = 0; i < 9; i++) tick();
    check_all("div_mid");
    rst_n = 0;
    check_all("div_rst");
    chk("div_rst_const", 8'(md_busy), 8'd0);
    tick();
    rst_n = 1; md_use_d = 1;
    check_all("post_rst");
    chk("post_rst_const", 8'(stall_f), 8'd0);
    tick();

    // md_busy clears under a persisting load-use hazard.
    clear_inputs();
    md_start_e = 1;
    tick();
    md_start_e = 0; md_use_d = 1; mem_to_reg_e = 1; rt_e = 4; rt_d = 4;
    for (int i = 0; i < MULT_C + 1; i++) begin
      check_all("md_lw");
      chk("md_lw_const", 8'(stall_f), 8'd1);
      tick();
    end
    mem_to_reg_e = 0;
    check_all("md_lw_end");
    chk("md_lw_end_const", 8'(stall_f), 8'd0);
    tick();

    // Randomized traffic with a small register space to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      write_reg_e = 5'($urandom_range(0, 3)); write_reg_m = 5'($urandom_range(0, 3));
      write_reg_w = 5'($urandom_range(0, 3));
      branch_d = 1'($urandom); md_use_d = 1'($urandom);
      reg_write_e = 1'($urandom); mem_to_reg_e = 1'($urandom);
      reg_write_m = 1'($urandom); mem_to_reg_m = 1'($urandom);
      reg_write_w = 1'($urandom);
      md_start_e = ($urandom_range(0, 7) == 0); md_div_e = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      check_all("rand");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
